// File: rtl/ma_pkg.sv
// Shared constants and command/response encodings for the dictionary compressor.
// Index validity is "idx < count"; storage beyond count is never trusted.
package ma_pkg;

    localparam int DATA_W = 80;
    localparam int IDX_W  = 8;
    localparam int DEPTH  = 256;
    localparam int CNT_W  = IDX_W + 1;

    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_COMP   = 2'd1,
        CMD_DECOMP = 2'd2,
        CMD_BAD    = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        RSP_IDLE      = 2'd0,
        RSP_COMP_OK   = 2'd1,
        RSP_DECOMP_OK = 2'd2,
        RSP_ERR       = 2'd3
    } resp_e;

    function automatic logic idx_valid(input logic [IDX_W-1:0] idx,
                                       input logic [CNT_W-1:0] count);
        return {1'b0, idx} < count;
    endfunction

endpackage

// File: rtl/ma_dict.sv
// Dictionary storage: one write port, one combinational read port and a
// parallel lookup returning the lowest valid matching index.
module ma_dict
    import ma_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] key,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  match;

    // Storage is deliberately not reset; the count mask defines what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = idx_valid(IDX_W'(i), count) && (mem[i] == key);
        end
    end

    // Scan downwards so the lowest matching index is the last one assigned.
    always_comb begin
        hit     = |match;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ma.sv
// Dictionary compressor top: command decode, fill counter and registered outputs.
// One command per clock, results visible the following cycle.
module ma
    import ma_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  compressed_in,
    input  logic [1:0]        command,
    output logic [IDX_W-1:0]  compressed_out,
    output logic [DATA_W-1:0] decompressed_out,
    output logic [1:0]        response
);

    cmd_e              cmd;
    resp_e             resp_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [IDX_W-1:0]  cout_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              wr_req;
    logic              wr_en;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [DATA_W-1:0] rd_data;

    assign cmd = cmd_e'(command);

    // Reset wins over a COMPRESS in the same cycle, so no write may land then.
    assign wr_en = wr_req & reset;

    ma_dict u_dict (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (count[IDX_W-1:0]),
        .wr_data (data_in),
        .count   (count),
        .key     (data_in),
        .hit     (hit),
        .hit_idx (hit_idx),
        .rd_idx  (compressed_in),
        .rd_data (rd_data)
    );

    always_comb begin
        count_nxt = count;
        cout_nxt  = compressed_out;
        dout_nxt  = decompressed_out;
        resp_nxt  = RSP_IDLE;
        wr_req    = 1'b0;
        case (cmd)
            CMD_NOP: begin
                resp_nxt = RSP_IDLE;
            end
            CMD_COMP: begin
                if (hit) begin
                    cout_nxt = hit_idx;
                    resp_nxt = RSP_COMP_OK;
                end else if (count != COUNT_FULL) begin
                    wr_req    = 1'b1;
                    cout_nxt  = count[IDX_W-1:0];
                    count_nxt = count + 1'b1;
                    resp_nxt  = RSP_COMP_OK;
                end else begin
                    resp_nxt = RSP_ERR;
                end
            end
            CMD_DECOMP: begin
                if (idx_valid(compressed_in, count)) begin
                    dout_nxt = rd_data;
                    resp_nxt = RSP_DECOMP_OK;
                end else begin
                    resp_nxt = RSP_ERR;
                end
            end
            default: begin
                resp_nxt = RSP_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count            <= '0;
            compressed_out   <= '0;
            decompressed_out <= '0;
            response         <= RSP_IDLE;
        end else begin
            count            <= count_nxt;
            compressed_out   <= cout_nxt;
            decompressed_out <= dout_nxt;
            response         <= resp_nxt;
        end
    end

endmodule

// File: tb/tb_ma.sv
// Self-checking bench for the dictionary compressor: directed scenarios plus
// randomized traffic compared against a queue-based dictionary model.
module tb_ma;

    logic        clk;
    logic        reset;
    logic [79:0] data_in;
    logic [7:0]  compressed_in;
    logic [1:0]  command;
    logic [7:0]  compressed_out;
    logic [79:0] decompressed_out;
    logic [1:0]  response;

    int n_cmp;
    int n_fail;

    logic [79:0] dict_q[$];
    logic [7:0]  exp_cout;
    logic [79:0] exp_dout;
    logic [1:0]  exp_resp;
    logic [79:0] pool[24];

    ma dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .compressed_in    (compressed_in),
        .command          (command),
        .compressed_out   (compressed_out),
        .decompressed_out (decompressed_out),
        .response         (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command at the falling edge, advance the model, then check
    // the registered outputs one falling edge later.
    task automatic step(input string tag, input logic rst_n, input logic [1:0] cmd,
                        input logic [79:0] d, input logic [7:0] ci);
        int hits[$];
        reset         = rst_n;
        command       = cmd;
        data_in       = d;
        compressed_in = ci;
        if (!rst_n) begin
            dict_q.delete();
            exp_cout = '0;
            exp_dout = '0;
            exp_resp = 2'd0;
        end else begin
            case (cmd)
                2'd0: exp_resp = 2'd0;
                2'd1: begin
                    hits = dict_q.find_first_index(x) with (x == d);
                    if (hits.size() > 0) begin
                        exp_cout = 8'(hits[0]);
                        exp_resp = 2'd1;
                    end else if (dict_q.size() < 256) begin
                        exp_cout = 8'(dict_q.size());
                        dict_q.push_back(d);
                        exp_resp = 2'd1;
                    end else begin
                        exp_resp = 2'd3;
                    end
                end
                2'd2: begin
                    if (int'(ci) < dict_q.size()) begin
                        exp_dout = dict_q[ci];
                        exp_resp = 2'd2;
                    end else begin
                        exp_resp = 2'd3;
                    end
                end
                default: exp_resp = 2'd3;
            endcase
        end
        @(negedge clk);
        chk({tag, ".resp"}, 80'(response), 80'(exp_resp));
        chk({tag, ".cout"}, 80'(compressed_out), 80'(exp_cout));
        chk({tag, ".dout"}, decompressed_out, exp_dout);
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        exp_cout = '0;
        exp_dout = '0;
        exp_resp = '0;
        reset = 1'b0;
        command = 2'd0;
        data_in = '0;
        compressed_in = '0;
        for (int i = 0; i < 24; i++) pool[i] = (i < 8) ? 80'(i) : rand80();

        @(negedge clk);
        step("rst0", 1'b0, 2'd0, 80'h0, 8'd0);
        step("rst1", 1'b0, 2'd1, 80'h55, 8'd0);

        // Basic compress / decompress / error handling
        step("comp7",      1'b1, 2'd1, 80'h7, 8'd0);
        step("decomp0",    1'b1, 2'd2, 80'h0, 8'd0);
        step("badcmd",     1'b1, 2'd3, 80'h7, 8'd0);
        step("comp7_hit",  1'b1, 2'd1, 80'h7, 8'd0);
        step("decomp1bad", 1'b1, 2'd2, 80'h0, 8'd1);
        step("comp_new",   1'b1, 2'd1, 80'h1234, 8'd0);
        step("decomp1ok",  1'b1, 2'd2, 80'h0, 8'd1);
        step("nop",        1'b1, 2'd0, 80'h7, 8'd0);

        // Fill from empty: 256 distinct words, then overflow and a hit when full
        step("fill_rst", 1'b0, 2'd0, 80'h0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            step("fill", 1'b1, 2'd1, {32'hA5A5_0000, 48'(i)}, 8'd0);
        end
        step("overflow",   1'b1, 2'd1, 80'hDEAD_BEEF, 8'd0);
        step("full_hit",   1'b1, 2'd1, {32'hA5A5_0000, 48'd77}, 8'd0);
        step("full_last",  1'b1, 2'd1, {32'hA5A5_0000, 48'd255}, 8'd0);
        step("full_dec255", 1'b1, 2'd2, 80'h0, 8'd255);
        step("full_dec0",   1'b1, 2'd2, 80'h0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            step("full_dec_rand", 1'b1, 2'd2, 80'h0, 8'($urandom_range(0, 255)));
        end

        // Stale storage after reset must not be matched or readable
        step("stale_rst",  1'b0, 2'd1, 80'h0, 8'd0);
        step("stale_dec",  1'b1, 2'd2, 80'h0, 8'd3);
        step("stale_comp", 1'b1, 2'd1, {32'hA5A5_0000, 48'd5}, 8'd0);
        step("stale_comp2", 1'b1, 2'd1, {32'hA5A5_0000, 48'd0}, 8'd0);

        // Reset mid-operation
        step("mid_rst0", 1'b0, 2'd0, 80'h0, 8'd0);
        step("store7",   1'b1, 2'd1, 80'h7, 8'd0);
        step("store8",   1'b1, 2'd1, 80'h8, 8'd0);
        step("mid_rst",  1'b0, 2'd1, 80'hABC, 8'd0);
        step("after_dec1", 1'b1, 2'd2, 80'h0, 8'd1);
        step("after_comp9", 1'b1, 2'd1, 80'h9, 8'd0);
        step("after_dec0",  1'b1, 2'd2, 80'h0, 8'd0);

        // Randomized traffic over a small word pool to mix hits and misses
        for (int n = 0; n < 600; n++) begin
            logic rst_n;
            rst_n = ($urandom_range(0, 59) != 0);
            step("rand", rst_n, 2'($urandom_range(0, 3)),
                 pool[$urandom_range(0, 23)], 8'($urandom_range(0, 30)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
